reg_burst_reader: RTL

REG_BURST_READER -- requirements
Module: reg_burst_reader

---
 rtl/reg_burst_reader_pkg.sv | 13 +
 rtl/stream_out_reg.sv | 33 +++
 rtl/reg_burst_reader.sv | 118 +++++++++++
 3 files changed

// File: rtl/reg_burst_reader_pkg.sv
// Shared types and default sizing for the register burst reader.
package reg_burst_reader_pkg;

   localparam int W_DEF = 5;
   localparam int B_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } state_t;

endpackage

// File: rtl/stream_out_reg.sv
// Registered output stage: word, valid and last flag with load/clear control.
module stream_out_reg
   import reg_burst_reader_pkg::*;
#(
   parameter int B = B_DEF
) (
   input  logic         clk,
   input  logic         n_reset,
   input  logic         load,
   input  logic         clear,
   input  logic [B-1:0] d,
   input  logic         last_in,
   output logic [B-1:0] m_data,
   output logic         m_valid,
   output logic         m_last
);

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         m_data  <= '0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
      end else if (clear) begin
         m_valid <= 1'b0;
         m_last  <= 1'b0;
      end else if (load) begin
         m_data  <= d;
         m_valid <= 1'b1;
         m_last  <= last_in;
      end
   end

endmodule

// File: rtl/reg_burst_reader.sv
// Streams a burst of register-file words to a valid/ready sink.
module reg_burst_reader
   import reg_burst_reader_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int B = B_DEF
) (
   input  logic         clk,
   input  logic         n_reset,
   input  logic         start,
   input  logic [W-1:0] base_addr,
   input  logic [W-1:0] len_m1,
   input  logic         abort,
   output logic [W-1:0] r_addr,
   input  logic [B-1:0] r_data,
   output logic [B-1:0] m_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic         m_last,
   output logic         busy,
   output logic         done
);

   state_t       state;
   state_t       state_nx;
   logic [W-1:0] addr_q;
   logic [W-1:0] rem_q;
   logic         cap;
   logic         load;
   logic         clear;
   logic         done_d;
   logic         done_q;
   logic         last_word;

   assign last_word = (rem_q == '0);
   assign r_addr    = addr_q;
   assign busy      = (state != IDLE);
   assign done      = done_q;

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state  <= IDLE;
         done_q <= 1'b0;
      end else begin
         state  <= state_nx;
         done_q <= done_d;
      end
   end

   // A new word is fetched whenever the output slot is empty or draining.
   always_comb begin
      state_nx = state;
      cap      = 1'b0;
      load     = 1'b0;
      clear    = 1'b0;
      done_d   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && !abort) begin
               cap      = 1'b1;
               state_nx = STREAM;
            end
         end
         STREAM: begin
            if (abort) begin
               clear    = 1'b1;
               state_nx = IDLE;
            end else if (!m_valid || m_ready) begin
               load = 1'b1;
               if (last_word) begin
                  state_nx = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (abort) begin
               clear    = 1'b1;
               state_nx = IDLE;
            end else if (m_valid && m_ready) begin
               clear    = 1'b1;
               done_d   = 1'b1;
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         addr_q <= '0;
         rem_q  <= '0;
      end else if (cap) begin
         addr_q <= base_addr;
         rem_q  <= len_m1;
      end else if (load) begin
         addr_q <= addr_q + W'(1);
         rem_q  <= rem_q - W'(1);
      end
   end

   stream_out_reg #(
      .B(B)
   ) u_out (
      .clk     (clk),
      .n_reset (n_reset),
      .load    (load),
      .clear   (clear),
      .d       (r_data),
      .last_in (last_word),
      .m_data  (m_data),
      .m_valid (m_valid),
      .m_last  (m_last)
   );

endmodule
